// File: rtl/sensor_cfg_seq.sv
// sensor_cfg_seq: walks a {addr,value} table and issues register writes to a sensor,
// with delay entries, NACK retries, power-up wait and restart.
module sensor_cfg_seq #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int REG_NUM      = 69,
  parameter int CNT_WAIT_MAX = 1023,
  parameter int DLY_UNIT     = 1000,
  parameter int MAX_RETRY    = 3
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     restart,
  output logic [9:0]               tbl_addr,
  input  logic [ADDR_W+DATA_W-1:0] tbl_data,
  output logic                     cfg_start,
  output logic [ADDR_W-1:0]        cfg_addr,
  output logic [DATA_W-1:0]        cfg_data,
  input  logic                     cfg_end,
  input  logic                     cfg_err,
  output logic                     cfg_done,
  output logic                     cfg_fail,
  output logic [9:0]               cfg_idx,
  output logic [7:0]               err_cnt
);
  localparam longint DLY_MAX = ((longint'(1) << DATA_W) - 1) * DLY_UNIT;
  localparam int WW = CNT_WAIT_MAX > 1 ? $clog2(CNT_WAIT_MAX) : 1;
  localparam int DW = DLY_MAX > 1 ? $clog2(DLY_MAX + 1) : 1;
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;

  typedef enum logic [2:0] {WAIT_PWR, FETCH, LATCH, ISSUE, BUSY, DELAY, DONE, FAIL} state_t;
  state_t state, state_n;

  logic [WW-1:0]     wait_cnt;
  logic [DW-1:0]     dly_cnt;
  logic [RW-1:0]     retry;
  logic [ADDR_W-1:0] tbl_a;
  logic [DATA_W-1:0] tbl_v;
  logic              is_dly, last, ack, nack, dly_end, rerun;

  assign {tbl_a, tbl_v} = tbl_data;
  assign is_dly  = &tbl_a;
  assign last    = cfg_idx == 10'(REG_NUM - 1);
  assign ack     = state == BUSY && cfg_end && !cfg_err;
  assign nack    = state == BUSY && cfg_end && cfg_err;
  assign dly_end = state == DELAY && dly_cnt == '0;
  assign rerun   = restart && (state == DONE || state == FAIL);

  assign tbl_addr  = cfg_idx;
  assign cfg_start = state == ISSUE;
  assign cfg_done  = state == DONE;
  assign cfg_fail  = state == FAIL;

  always_comb begin
    state_n = state;
    case (state)
      WAIT_PWR: state_n = wait_cnt == WW'(CNT_WAIT_MAX - 1) ? FETCH : WAIT_PWR;
      FETCH:    state_n = LATCH;
      LATCH:    state_n = is_dly ? DELAY : ISSUE;
      ISSUE:    state_n = BUSY;
      BUSY:     state_n = nack ? (retry < RW'(MAX_RETRY) ? ISSUE : FAIL) :
                          ack  ? (last ? DONE : FETCH) : BUSY;
      DELAY:    state_n = dly_end ? (last ? DONE : FETCH) : DELAY;
      DONE:     state_n = restart ? FETCH : DONE;
      FAIL:     state_n = restart ? FETCH : FAIL;
      default:  state_n = WAIT_PWR;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= WAIT_PWR;
      wait_cnt <= '0;
      dly_cnt  <= '0;
      retry    <= '0;
      cfg_addr <= '0;
      cfg_data <= '0;
      cfg_idx  <= '0;
      err_cnt  <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= state == WAIT_PWR ? wait_cnt + WW'(1) : '0;
      // a delay of value*DLY_UNIT clocks counts down to zero; value 0 still costs one clock
      if (state == LATCH)
        dly_cnt <= (is_dly && |tbl_v) ? DW'(tbl_v) * DW'(DLY_UNIT) - DW'(1) : '0;
      else if (state == DELAY && dly_cnt != '0)
        dly_cnt <= dly_cnt - DW'(1);
      if (state == LATCH) begin
        cfg_addr <= tbl_a;
        cfg_data <= tbl_v;
      end else if (state_n == DONE) begin
        cfg_addr <= '0;
        cfg_data <= '0;
      end
      if (rerun) begin
        cfg_idx <= '0;
        err_cnt <= '0;
        retry   <= '0;
      end else begin
        if ((ack || dly_end) && !last) cfg_idx <= cfg_idx + 10'd1;
        if (ack) retry <= '0;
        else if (nack && retry < RW'(MAX_RETRY)) retry <= retry + RW'(1);
        if (nack && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end
    end
  end
endmodule
